// File: rtl/plot_arbiter_pkg.sv
// Shared state encoding, default sizing and index-width helper for the VGA plot arbiter.
`timescale 1ns/1ps
package plot_arbiter_pkg;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_GRANT   = 2'd1,
      S_RELEASE = 2'd2
   } state_t;

   localparam int N_REQ_DEF     = 4;
   localparam int MAX_BURST_DEF = 1024;

   // Width of an index/counter over n values; never narrower than one bit.
   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/plot_arbiter_rr_pick.sv
// Combinational round-robin finder: first asserted request after the last grant, wrapping.
`timescale 1ns/1ps
module rr_pick
   import plot_arbiter_pkg::*;
#(
   parameter  int N_REQ = N_REQ_DEF,
   localparam int LW    = idx_w(N_REQ)
) (
   input  logic [N_REQ-1:0] i_req,
   input  logic [LW-1:0]    i_last,
   output logic [LW-1:0]    o_winner,
   output logic             o_valid
);

   int unsigned w_idx;

   always_comb begin
      o_winner = '0;
      o_valid  = 1'b0;
      w_idx    = 0;
      for (int unsigned k = 1; k <= N_REQ; k++) begin
         w_idx = (32'(i_last) + k) % N_REQ;
         if (!o_valid && i_req[LW'(w_idx)]) begin
            o_valid  = 1'b1;
            o_winner = LW'(w_idx);
         end
      end
   end

endmodule

// File: rtl/plot_arbiter.sv
// Round-robin arbiter sharing one VGA plot port among N_REQ drawing requesters, with burst limit.
`timescale 1ns/1ps
module plot_arbiter
   import plot_arbiter_pkg::*;
#(
   parameter int N_REQ     = N_REQ_DEF,
   parameter int MAX_BURST = MAX_BURST_DEF
) (
   input  logic                 clk,
   input  logic                 resetn,
   input  logic [N_REQ-1:0]     req,
   input  logic [N_REQ-1:0]     plot_in,
   input  logic [10*N_REQ-1:0]  x_in,
   input  logic [10*N_REQ-1:0]  y_in,
   input  logic [3*N_REQ-1:0]   colour_in,
   output logic [N_REQ-1:0]     grant,
   output logic [9:0]           x,
   output logic [9:0]           y,
   output logic [2:0]           colour,
   output logic                 writeEn,
   output logic                 busy
);

   localparam int LW = idx_w(N_REQ);
   localparam int BW = idx_w(MAX_BURST);
   localparam logic [BW-1:0] BURST_LAST = BW'(MAX_BURST - 1);

   state_t           r_state, w_next;
   logic [LW-1:0]    r_last, w_winner;
   logic             w_valid;
   logic [BW-1:0]    r_burst;
   logic [N_REQ-1:0] r_grant, w_onehot;
   logic [9:0]       r_x, r_y, w_x_g, w_y_g;
   logic [2:0]       r_colour, w_c_g;
   logic             r_we, w_plot_g, w_req_g, w_timeout, w_exit;

   rr_pick #(.N_REQ(N_REQ)) u_rr_pick (
      .i_req    (req),
      .i_last   (r_last),
      .o_winner (w_winner),
      .o_valid  (w_valid)
   );

   // r_last doubles as the granted index for the whole burst.
   always_comb begin
      w_req_g   = req[r_last];
      w_plot_g  = plot_in[r_last];
      w_x_g     = x_in[10*int'(r_last) +: 10];
      w_y_g     = y_in[10*int'(r_last) +: 10];
      w_c_g     = colour_in[3*int'(r_last) +: 3];
      w_timeout = (r_burst == BURST_LAST);
      w_exit    = !w_req_g || w_timeout;
      w_onehot  = '0;
      for (int unsigned i = 0; i < N_REQ; i++) w_onehot[i] = (w_winner == LW'(i));
   end

   always_ff @(posedge clk) begin
      if (!resetn) r_state <= S_IDLE;
      else         r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:    if (w_valid) w_next = S_GRANT;
         S_GRANT:   if (w_exit)  w_next = S_RELEASE;
         S_RELEASE: w_next = S_IDLE;
         default:   w_next = S_IDLE;
      endcase
   end

   always_comb begin
      busy = (r_state != S_IDLE);
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         r_grant  <= '0;
         r_we     <= 1'b0;
         r_x      <= '0;
         r_y      <= '0;
         r_colour <= '0;
         r_burst  <= '0;
         r_last   <= LW'(N_REQ - 1);
      end else begin
         case (r_state)
            S_IDLE: begin
               r_we <= 1'b0;
               if (w_valid) begin
                  r_grant <= w_onehot;
                  r_last  <= w_winner;
                  r_burst <= '0;
               end
            end
            S_GRANT: begin
               // A dropped request discards this cycle's sample; a timeout still commits it.
               if (!w_req_g) begin
                  r_grant <= '0;
                  r_we    <= 1'b0;
               end else begin
                  r_x      <= w_x_g;
                  r_y      <= w_y_g;
                  r_colour <= w_c_g;
                  r_we     <= w_plot_g;
                  if (w_timeout) r_grant <= '0;
                  else           r_burst <= r_burst + 1'b1;
               end
            end
            default: r_we <= 1'b0;
         endcase
      end
   end

   assign grant   = r_grant;
   assign x       = r_x;
   assign y       = r_y;
   assign colour  = r_colour;
   assign writeEn = r_we;

endmodule

// File: tb/tb_plot_arbiter.sv
// Directed bench for plot_arbiter: vector table plus hand sequences for round-robin, burst limit and reset.
`timescale 1ns/1ps
module tb_plot_arbiter;

   logic        clk = 1'b0;
   logic        resetn;
   logic [3:0]  req, plot;
   logic [9:0]  xa [4];
   logic [9:0]  ya [4];
   logic [2:0]  ca [4];
   logic [39:0] x_in, y_in;
   logic [11:0] colour_in;

   logic [3:0] g8, g4;
   logic [9:0] x8, y8, x4, y4;
   logic [2:0] c8, c4;
   logic       we8, we4, b8, b4;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   always_comb begin
      x_in      = {xa[3], xa[2], xa[1], xa[0]};
      y_in      = {ya[3], ya[2], ya[1], ya[0]};
      colour_in = {ca[3], ca[2], ca[1], ca[0]};
   end

   plot_arbiter #(.N_REQ(4), .MAX_BURST(8)) dut (
      .clk(clk), .resetn(resetn), .req(req), .plot_in(plot),
      .x_in(x_in), .y_in(y_in), .colour_in(colour_in),
      .grant(g8), .x(x8), .y(y8), .colour(c8), .writeEn(we8), .busy(b8)
   );

   plot_arbiter #(.N_REQ(4), .MAX_BURST(4)) dut4 (
      .clk(clk), .resetn(resetn), .req(req), .plot_in(plot),
      .x_in(x_in), .y_in(y_in), .colour_in(colour_in),
      .grant(g4), .x(x4), .y(y4), .colour(c4), .writeEn(we4), .busy(b4)
   );

   typedef struct {
      logic [3:0] req;
      logic [3:0] plot;
      logic [9:0] x0;
      logic [9:0] x2;
      logic [3:0] e_grant;
      logic       e_we;
      logic [9:0] e_x;
      logic [9:0] e_y;
      logic [2:0] e_c;
      logic       e_busy;
   } vec_t;

   vec_t vt [11];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      resetn = 1'b0;
      req    = '0;
      plot   = '0;
      tick();
      resetn = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [3:0] pat [3];
      logic [3:0] oh;

      for (int i = 0; i < 4; i++) begin xa[i] = '0; ya[i] = '0; ca[i] = '0; end
      ya[0] = 10'd7;  ca[0] = 3'b100;
      ya[2] = 10'd55; ca[2] = 3'b001;

      //        req      plot     x0  x2   grant    we  x   y   c  busy
      vt[0]  = '{4'b0001, 4'b0001, 5, 0,  4'b0001, 0, 0,  0,  0, 1};
      vt[1]  = '{4'b0001, 4'b0001, 5, 0,  4'b0001, 1, 5,  7,  4, 1};
      vt[2]  = '{4'b0001, 4'b0101, 6, 99, 4'b0001, 1, 6,  7,  4, 1};
      vt[3]  = '{4'b0001, 4'b0100, 6, 99, 4'b0001, 0, 6,  7,  4, 1};
      vt[4]  = '{4'b0101, 4'b0101, 8, 99, 4'b0001, 1, 8,  7,  4, 1};
      vt[5]  = '{4'b0100, 4'b0101, 9, 99, 4'b0000, 0, 8,  7,  4, 1};
      vt[6]  = '{4'b0100, 4'b0100, 9, 99, 4'b0000, 0, 8,  7,  4, 0};
      vt[7]  = '{4'b0100, 4'b0100, 9, 99, 4'b0100, 0, 8,  7,  4, 1};
      vt[8]  = '{4'b0100, 4'b0100, 9, 99, 4'b0100, 1, 99, 55, 1, 1};
      vt[9]  = '{4'b0000, 4'b0000, 9, 99, 4'b0000, 0, 99, 55, 1, 1};
      vt[10] = '{4'b0000, 4'b0000, 9, 99, 4'b0000, 0, 99, 55, 1, 0};

      // Reset state
      do_reset();
      chk("rst_grant", 32'(g8), 0);
      chk("rst_we",    32'(we8), 0);
      chk("rst_x",     32'(x8), 0);
      chk("rst_y",     32'(y8), 0);
      chk("rst_col",   32'(c8), 0);
      chk("rst_busy",  32'(b8), 0);

      // Vector table: single grant, data path, foreign plot ignored, drop and re-grant
      for (int v = 0; v < 11; v++) begin
         req = vt[v].req; plot = vt[v].plot; xa[0] = vt[v].x0; xa[2] = vt[v].x2;
         tick();
         chk($sformatf("vec%0d_grant", v), 32'(g8),  32'(vt[v].e_grant));
         chk($sformatf("vec%0d_we", v),    32'(we8), 32'(vt[v].e_we));
         chk($sformatf("vec%0d_x", v),     32'(x8),  32'(vt[v].e_x));
         chk($sformatf("vec%0d_y", v),     32'(y8),  32'(vt[v].e_y));
         chk($sformatf("vec%0d_col", v),   32'(c8),  32'(vt[v].e_c));
         chk($sformatf("vec%0d_busy", v),  32'(b8),  32'(vt[v].e_busy));
      end

      // Round-robin through all four with two dead cycles between grants
      do_reset();
      req = 4'b1111;
      tick();
      for (int k = 0; k < 4; k++) begin
         oh = 4'(1 << k);
         for (int c = 0; c < 3; c++) begin
            chk($sformatf("rr%0d_grant_c%0d", k, c), 32'(g8), 32'(oh));
            if (c < 2) tick();
         end
         req[k] = 1'b0;
         tick();
         chk($sformatf("rr%0d_release", k), 32'(g8), 0);
         tick();
         chk($sformatf("rr%0d_idle", k), 32'(g8), 0);
         chk($sformatf("rr%0d_idle_busy", k), 32'(b8), 0);
         tick();
      end
      chk("rr_end_grant", 32'(g8), 0);

      // Burst limit 8 with two contenders: alternation, timeout sample committed
      do_reset();
      req = 4'b0011; plot = 4'b0011; xa[0] = 10'd11; xa[1] = 10'd22;
      pat[0] = 4'b0001; pat[1] = 4'b0010; pat[2] = 4'b0001;
      tick();
      for (int p = 0; p < 3; p++) begin
         for (int c = 0; c < 8; c++) begin
            chk($sformatf("burst%0d_c%0d", p, c), 32'(g8), 32'(pat[p]));
            tick();
         end
         chk($sformatf("burst%0d_rel_grant", p), 32'(g8), 0);
         chk($sformatf("burst%0d_rel_we", p), 32'(we8), 1);
         chk($sformatf("burst%0d_rel_x", p), 32'(x8), (p == 1) ? 22 : 11);
         tick();
         chk($sformatf("burst%0d_idle_grant", p), 32'(g8), 0);
         chk($sformatf("burst%0d_idle_we", p), 32'(we8), 0);
         tick();
      end

      // Reset mid-burst aborts and restarts arbitration from requester 0
      do_reset();
      req = 4'b0100; plot = 4'b0100; xa[2] = 10'd33;
      tick();
      tick();
      chk("mid_grant", 32'(g8), 32'(4'b0100));
      chk("mid_we", 32'(we8), 1);
      chk("mid_x", 32'(x8), 33);
      resetn = 1'b0;
      tick();
      chk("mid_rst_grant", 32'(g8), 0);
      chk("mid_rst_we", 32'(we8), 0);
      chk("mid_rst_busy", 32'(b8), 0);
      resetn = 1'b1; req = 4'b0101;
      tick();
      chk("mid_next_grant", 32'(g8), 32'(4'b0001));

      // Single requester with burst limit 4: timeout, release, idle, re-grant
      do_reset();
      req = 4'b0100; plot = 4'b0000;
      tick();
      for (int c = 0; c < 4; c++) begin
         chk($sformatf("solo_c%0d", c), 32'(g4), 32'(4'b0100));
         tick();
      end
      chk("solo_rel_grant", 32'(g4), 0);
      chk("solo_rel_busy", 32'(b4), 1);
      tick();
      chk("solo_idle_grant", 32'(g4), 0);
      chk("solo_idle_busy", 32'(b4), 0);
      tick();
      chk("solo_regrant", 32'(g4), 32'(4'b0100));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
